gf2m_trinomial_reducer: RTL and testbench
=========================================

GF2M_TRINOMIAL_REDUCER -- requirements
Module: gf2m_trinomial_reducer

Interface
REQ-001 The block SHALL expose parameter M, default 521, the field degree.
REQ-002 The block SHALL expose parameter K, default 32, the middle-term exponent of the reduction polynomial x^M + x^K + 1.
REQ-003 The block SHALL expose parameter IN_W, default 1042, the width of the unreduced product input.
REQ-004 clk  input  1  Single clock; all state changes on the rising edge.
REQ-005 rst  input  1  Reset; asynchronous, active-low.
REQ-006 in_valid  input  1  Unreduced product on in_data is valid.
REQ-007 in_ready  output  1  Block can accept a product.
REQ-008 in_data  input  IN_W  Carry-less product from the upstream four-way Toom-Cook multiplier; bit n is the coefficient of x^n.
REQ-009 out_valid  output  1  out_data holds a reduced field element.
REQ-010 out_ready  input  1  Downstream accepts out_data.
REQ-011 out_data  output  M  Result of in_data mod (x^M + x^K + 1).
REQ-012 fold_cnt  output  2  Number of fold cycles used for the current result; valid while out_valid=1.

Function
REQ-013 The block SHALL implement the FSM states IDLE, FOLD and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in FOLD and DONE, in_ready SHALL be 0, so the block holds at most one product at a time.
REQ-015 IDLE: on in_valid=1, the block SHALL capture acc <= in_data, set fold_cnt <= 0 and go to FOLD; with in_valid=0 it SHALL stay in IDLE.
REQ-016 FOLD, when hi = acc[IN_W-1:M] != 0: acc <= acc[M-1:0] XOR hi XOR (hi << K), computed over IN_W bits; fold_cnt <= fold_cnt + 1; the FSM SHALL stay in FOLD.
REQ-017 FOLD, when hi == 0: out_data <= acc[M-1:0], out_valid <= 1, and the FSM SHALL go to DONE.
REQ-018 For M=521, K=32 and any IN_W=1042 input, at most 2 folds SHALL be needed, so fold_cnt SHALL never exceed 2.
REQ-019 Latency from the accept edge to out_valid=1 SHALL be fold_cnt + 1 cycles, i.e. 1 to 3 cycles.
REQ-020 DONE: out_valid and out_data SHALL stay stable until out_ready=1; on out_ready=1 the block SHALL clear out_valid and return to IDLE.
REQ-021 The accept and the output handshake SHALL not overlap: the next product is accepted no earlier than the cycle after the DONE-to-IDLE transition.
REQ-022 in_data bit IN_W-1 SHALL be reduced like every other bit and SHALL NOT be ignored.
REQ-023 in_valid asserted outside IDLE SHALL have no effect; upstream SHALL hold in_valid and in_data until in_ready=1.
REQ-024 All arithmetic SHALL be GF(2) (XOR only), with no carries.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, fold_cnt=0 and acc=0.
REQ-026 A reset during FOLD or DONE SHALL discard the in-flight product, with no output produced for it.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-028 A shared package SHALL hold M, K, IN_W, the derived width HI_W = IN_W-M, and the FSM state enumeration.
REQ-029 The single fold step SHALL be a purely combinational sub-module gf2m_trinomial_fold (acc in, folded acc and hi_zero flag out), instantiated once.
REQ-030 The block SHALL contain no multipliers and no wide shifters other than the constant shift by K.

Verification
REQ-031 Input with only bit 1040 set -> out_data has bits {519, 62, 30} set, fold_cnt=2, out_valid 3 cycles after accept.
REQ-032 Input with only bit 521 set -> out_data has bits {32, 0} set, fold_cnt=1, latency 2.
REQ-033 Input with only bit 1041 set -> out_data has bits {520, 63, 31} set, fold_cnt=2.
REQ-034 Input with only bits [520:0] set, value 0x1F5 -> out_data=0x1F5, fold_cnt=0, latency 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0 and a new in_valid ignored; release -> return to IDLE.
REQ-036 rst pulsed low in the FOLD cycle -> out_valid=0 immediately with no output for that product; random back-to-back products then match the software reference (carry-less multiply, then mod x^521+x^32+1).

Source files
------------

// File: rtl/gf2m_trinomial_reducer_pkg.sv
// Shared constants and state encoding for the GF(2^m) trinomial reducer.
//   GfM    : field degree m
//   GfK    : middle-term exponent k of x^m + x^k + 1
//   GfInW  : width of the unreduced carry-less product
//   GfHiW  : width of the part above x^(m-1) that gets folded back
package gf2m_trinomial_reducer_pkg;

  localparam int unsigned GfM   = 521;
  localparam int unsigned GfK   = 32;
  localparam int unsigned GfInW = 1042;
  localparam int unsigned GfHiW = GfInW - GfM;

  typedef enum logic [1:0] {
    StIdle,
    StFold,
    StDone
  } state_e;

endpackage

// File: rtl/gf2m_trinomial_fold.sv
// One combinational fold step of reduction modulo x^M + x^K + 1.
// Because x^M == x^K + 1, the high part hi = acc[IN_W-1:M] is folded back as
// acc[M-1:0] ^ hi ^ (hi << K), computed over the full IN_W width.
// Ports:
//   acc        : partially reduced polynomial, bit n = coefficient of x^n
//   acc_folded : acc after one fold
//   hi_zero    : 1 when acc already has degree < M (no fold needed)
module gf2m_trinomial_fold
  import gf2m_trinomial_reducer_pkg::*;
#(
  parameter int unsigned M    = GfM,
  parameter int unsigned K    = GfK,
  parameter int unsigned IN_W = GfInW
) (
  input  logic [IN_W-1:0] acc,
  output logic [IN_W-1:0] acc_folded,
  output logic            hi_zero
);

  localparam int unsigned HiW = IN_W - M;

  logic [IN_W-1:0] lo_ext;
  logic [IN_W-1:0] hi_ext;

  always_comb begin
    lo_ext          = '0;
    lo_ext[M-1:0]   = acc[M-1:0];
    hi_ext          = '0;
    hi_ext[HiW-1:0] = acc[IN_W-1:M];
  end

  // Only a constant shift: no barrel shifter is built.
  assign acc_folded = lo_ext ^ hi_ext ^ (hi_ext << K);
  assign hi_zero    = (acc[IN_W-1:M] == '0);

endmodule

// File: rtl/gf2m_trinomial_reducer.sv
// Reduces an unreduced carry-less product modulo x^M + x^K + 1.
// Accepts one product at a time (valid/ready), folds it iteratively until its
// degree is below M, then presents the field element until taken downstream.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : in_data holds a product
//   in_ready  : block is idle and can accept a product
//   in_data   : product, bit n = coefficient of x^n
//   out_valid : out_data holds a reduced element
//   out_ready : downstream takes out_data
//   out_data  : in_data mod (x^M + x^K + 1)
//   fold_cnt  : fold cycles spent on the current result
module gf2m_trinomial_reducer
  import gf2m_trinomial_reducer_pkg::*;
#(
  parameter int unsigned M    = GfM,
  parameter int unsigned K    = GfK,
  parameter int unsigned IN_W = GfInW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    out_data,
  output logic [1:0]      fold_cnt
);

  state_e          state_q, state_d;
  logic [IN_W-1:0] acc_q, acc_d;
  logic [M-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      fold_cnt_q, fold_cnt_d;

  logic [IN_W-1:0] acc_folded;
  logic            hi_zero;

  gf2m_trinomial_fold #(
    .M    (M),
    .K    (K),
    .IN_W (IN_W)
  ) u_fold (
    .acc        (acc_q),
    .acc_folded (acc_folded),
    .hi_zero    (hi_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      fold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fold_cnt_q  <= fold_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fold_cnt_d  = fold_cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d      = in_data;
          fold_cnt_d = '0;
          state_d    = StFold;
        end
      end
      StFold: begin
        if (!hi_zero) begin
          acc_d      = acc_folded;
          fold_cnt_d = fold_cnt_q + 2'd1;
        end else begin
          out_data_d  = acc_q[M-1:0];
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fold_cnt  = fold_cnt_q;

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Self-checking bench for gf2m_trinomial_reducer: directed vector table,
// stall/reset sequences, and random products against a long-division model.
module tb_gf2m_trinomial_reducer;

  localparam int M    = 521;
  localparam int K    = 32;
  localparam int IN_W = 1042;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [M-1:0]    out_data;
  logic [1:0]      fold_cnt;

  int checks = 0;
  int errors = 0;

  gf2m_trinomial_reducer #(
    .M    (M),
    .K    (K),
    .IN_W (IN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fold_cnt  (fold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [IN_W-1:0] din;
    logic [M-1:0]    exp_data;
    int              exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference reduction by schoolbook long division, one top bit at a time.
  function automatic logic [M-1:0] ref_mod(input logic [IN_W-1:0] p);
    logic [IN_W-1:0] r;
    r = p;
    for (int n = IN_W - 1; n >= M; n--) begin
      if (r[n]) begin
        r[n]         = 1'b0;
        r[n - M + K] = r[n - M + K] ^ 1'b1;
        r[n - M]     = r[n - M] ^ 1'b1;
      end
    end
    return r[M-1:0];
  endfunction

  // Number of whole-high-part folds x^M -> x^K + 1 until degree < M.
  function automatic int ref_folds(input logic [IN_W-1:0] p);
    logic [IN_W-1:0] r, hi, lo_mask;
    int              n;
    r       = p;
    n       = 0;
    lo_mask = '0;
    for (int i = 0; i < M; i++) lo_mask[i] = 1'b1;
    while ((r & ~lo_mask) != '0 && n < 8) begin
      hi = r >> M;
      r  = (r & lo_mask) ^ hi ^ (hi << K);
      n++;
    end
    return n;
  endfunction

  function automatic logic [IN_W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [IN_W-1:0] p, a_ext;
    p     = '0;
    a_ext = '0;
    a_ext[M-1:0] = a;
    for (int i = 0; i < M; i++) if (b[i]) p = p ^ (a_ext << i);
    return p;
  endfunction

  function automatic logic [IN_W-1:0] rand_wide();
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < IN_W; i += 32) v = {v[IN_W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Full transaction: wait ready, accept, measure latency, check, handshake out.
  task automatic xact(input string name, input logic [IN_W-1:0] din,
                      input logic [M-1:0] exp_d, input int exp_cnt);
    int waited;
    int lat;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({name, " ready_before"}, M'(in_ready), M'(1));
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, M'(lat), M'(exp_cnt + 1));
    chk({name, " out_data"}, out_data, exp_d);
    chk({name, " fold_cnt"}, M'(fold_cnt), M'(exp_cnt));
    chk({name, " busy"}, M'(in_ready), M'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " valid_clr"}, M'(out_valid), M'(0));
    chk({name, " ready_after"}, M'(in_ready), M'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] v;
    logic [M-1:0]    e;
    logic [M-1:0]    a, b;

    // Directed vectors.
    v = '0; v[1040] = 1'b1;
    e = '0; e[519] = 1'b1; e[62] = 1'b1; e[30] = 1'b1;
    vecs[0] = '{"bit1040", v, e, 2};
    v = '0; v[521] = 1'b1;
    e = '0; e[32] = 1'b1; e[0] = 1'b1;
    vecs[1] = '{"bit521", v, e, 1};
    v = '0; v[1041] = 1'b1;
    e = '0; e[520] = 1'b1; e[63] = 1'b1; e[31] = 1'b1;
    vecs[2] = '{"bit1041", v, e, 2};
    v = '0; v[8:0] = 9'h1F5;
    e = '0; e[8:0] = 9'h1F5;
    vecs[3] = '{"low1f5", v, e, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", M'(out_valid), M'(0));
    chk("rst out_data", out_data, '0);
    chk("rst fold_cnt", M'(fold_cnt), M'(0));
    chk("rst in_ready", M'(in_ready), M'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first in_ready", M'(in_ready), M'(1));

    foreach (vecs[i]) xact(vecs[i].name, vecs[i].din, vecs[i].exp_data, vecs[i].exp_cnt);

    // Output stall: data held, busy, new input ignored.
    in_valid = 1'b1;
    in_data  = vecs[0].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall reached", M'(out_valid), M'(1));
    in_valid = 1'b1;
    in_data  = vecs[1].din;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid", c), M'(out_valid), M'(1));
      chk($sformatf("stall%0d data", c), out_data, vecs[0].exp_data);
      chk($sformatf("stall%0d ready", c), M'(in_ready), M'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release valid", M'(out_valid), M'(0));
    chk("stall release ready", M'(in_ready), M'(1));
    @(posedge clk); #1;
    chk("stall ignored input", M'(out_valid), M'(0));

    // Reset in the middle of folding discards the product.
    in_valid = 1'b1;
    in_data  = vecs[0].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst out_valid", M'(out_valid), M'(0));
    chk("midrst fold_cnt", M'(fold_cnt), M'(0));
    chk("midrst out_data", out_data, '0);
    chk("midrst in_ready", M'(in_ready), M'(1));
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst%0d valid", c), M'(out_valid), M'(0));
    end

    // Random field products, back to back.
    for (int t = 0; t < 20; t++) begin
      a = M'(rand_wide());
      b = M'(rand_wide());
      v = clmul(a, b);
      xact($sformatf("clmul%0d", t), v, ref_mod(v), ref_folds(v));
    end
    // Random raw inputs including bit IN_W-1.
    for (int t = 0; t < 10; t++) begin
      v = rand_wide();
      xact($sformatf("raw%0d", t), v, ref_mod(v), ref_folds(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
